// File: rtl/riscv_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, sitting beside data RAM on
// the core's data bus. Register reads are combinational for single-cycle loads.
module riscv_mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        sel_o,
    output logic [31:0] rdata_o,
    output logic        txd_o,
    output logic        irq_o
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, pop, push_req, push_ok, wr_en;
    logic [1:0]    reg_off;
    logic          ovf;
    logic [15:0]   divisor;

    state_t        state, state_next;
    logic [7:0]    shift_q, shift_d;
    logic [15:0]   period_q, period_d, cyc_q, cyc_d;
    logic [2:0]    bit_q, bit_d;
    logic          bit_end, txd_d;

    logic          unused_bits;
    assign unused_bits = ^{addr_i[1:0], wdata_i[31:16]};

    assign sel_o    = (addr_i[31:4] == BASE_ADDR[31:4]);
    assign wr_en    = ce_i & we_i & sel_o;
    assign reg_off  = addr_i[3:2];
    assign push_req = wr_en & (reg_off == 2'd0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign pop      = (state == IDLE) & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok  = push_req & (~full | pop);
    assign bit_end  = (cyc_q == period_q - 16'd1);

    // Combinational register read mux; zero unless this window is accessed
    always_comb begin
        rdata_o = '0;
        if (ce_i && sel_o) begin
            case (reg_off)
                2'd1:    rdata_o = {20'd0, 4'(count), 4'd0, ovf, (state != IDLE), empty, full};
                2'd2:    rdata_o = {16'd0, divisor};
                default: rdata_o = '0;
            endcase
        end
    end

    // FIFO storage (no reset needed, validity tracked by count)
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= wdata_i[7:0];
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
        end
    end

    // Control registers: sticky overflow (set beats clear) and bit divisor
    always_ff @(posedge clk) begin
        if (!clrn) begin
            ovf     <= 1'b0;
            divisor <= DIV_RESET;
        end else begin
            if (push_req && !push_ok)                         ovf <= 1'b1;
            else if (wr_en && reg_off == 2'd1 && wdata_i[3]) ovf <= 1'b0;
            if (wr_en && reg_off == 2'd2) divisor <= wdata_i[15:0];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!clrn) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and datapath next values; bit period latched at pop
    always_comb begin
        state_next = state;
        shift_d    = shift_q;
        period_d   = period_q;
        cyc_d      = cyc_q;
        bit_d      = bit_q;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = START;
                    shift_d    = fifo_mem[rd_ptr];
                    period_d   = (divisor < 16'd2) ? 16'd1 : divisor;
                    cyc_d      = '0;
                    bit_d      = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    cyc_d      = '0;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cyc_d = '0;
                    if (bit_q == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            default: begin
                if (bit_end) begin
                    state_next = IDLE;
                    cyc_d      = '0;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
        endcase
    end

    // Line level for the state being entered, so txd_o tracks the FSM without lag
    always_comb begin
        case (state_next)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!clrn) begin
            shift_q  <= '0;
            period_q <= 16'd1;
            cyc_q    <= '0;
            bit_q    <= '0;
            txd_o    <= 1'b1;
            irq_o    <= 1'b1;
        end else begin
            shift_q  <= shift_d;
            period_q <= period_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            txd_o    <= txd_d;
            irq_o    <= empty & (state == IDLE);
        end
    end

endmodule

// File: tb/tb_riscv_mmio_uart_tx.sv
// Directed testbench for riscv_mmio_uart_tx: register access, frame timing,
// FIFO overflow, divisor latching, reset abort and address decode.
module tb_riscv_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        ce_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        sel_o;
    logic [31:0] rdata_o;
    logic        txd_o;
    logic        irq_o;

    int n_vec = 0;
    int n_err = 0;

    riscv_mmio_uart_tx #(
        .BASE_ADDR (32'h1000_0000),
        .FIFO_DEPTH(8),
        .DIV_RESET (16'd434)
    ) dut (
        .clk    (clk),
        .clrn   (clrn),
        .ce_i   (ce_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .wdata_i(wdata_i),
        .sel_o  (sel_o),
        .rdata_o(rdata_o),
        .txd_o  (txd_o),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ce_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
        @(posedge clk);
        #1;
        ce_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic s);
        @(negedge clk);
        ce_i = 1'b1; we_i = 1'b0; addr_i = a;
        #1;
        d = rdata_o;
        s = sel_o;
        ce_i = 1'b0;
    endtask

    // Called at posedge+1; returns the idle cycles seen before the start bit and
    // leaves time at the first cycle after the frame.
    task automatic frame_check(input string tag, input logic [7:0] b, input int p, output int w);
        logic exp;
        int   bi;
        w = 0;
        while (txd_o !== 1'b0 && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        if (txd_o !== 1'b0) begin
            check_eq({tag, "_start_timeout"}, {31'd0, txd_o}, 32'd0);
            return;
        end
        for (int i = 0; i < 10 * p; i++) begin
            bi = i / p;
            if (bi == 0)      exp = 1'b0;
            else if (bi == 9) exp = 1'b1;
            else              exp = b[bi-1];
            check_eq($sformatf("%s_bit%0d_cyc%0d", tag, bi, i % p), {31'd0, txd_o}, {31'd0, exp});
            @(posedge clk); #1;
        end
    endtask

    logic [31:0] rd;
    logic        s;
    int          w, w2, k;

    initial begin
        // 1: reset state
        repeat (2) @(posedge clk);
        #1 clrn = 1'b1;
        check_eq("rst_txd", {31'd0, txd_o}, 32'd1);
        check_eq("rst_irq", {31'd0, irq_o}, 32'd1);
        bus_read(BASE + 32'h4, rd, s);
        check_eq("rst_status", rd, 32'h0000_0002);
        check_eq("rst_sel", {31'd0, s}, 32'd1);
        bus_read(BASE + 32'h8, rd, s);
        check_eq("rst_div", rd, 32'd434);
        addr_i = BASE + 32'h4; #1;
        check_eq("rdata_no_ce", rdata_o, 32'd0);

        // 2: single 0x55 frame at P=4, one cycle from push to start bit
        bus_write(BASE + 32'h8, 32'hFFFF_0004);
        bus_read(BASE + 32'hB, rd, s);
        check_eq("div_rd_bytelanes", rd, 32'd4);
        @(posedge clk); #1;
        bus_write(BASE + 32'h0, 32'h0000_0055);
        frame_check("f55", 8'h55, 4, w);
        check_eq("f55_latency", w, 32'd1);
        check_eq("f55_irq_lag", {31'd0, irq_o}, 32'd0);
        @(posedge clk); #1;
        check_eq("f55_irq_done", {31'd0, irq_o}, 32'd1);

        // 3: fill while a frame is active, then overflow and clear
        for (int i = 0; i < 9; i++) bus_write(BASE + 32'h0, 32'h10 + i);
        bus_read(BASE + 32'h4, rd, s);
        check_eq("fill_status", rd, 32'h0000_0805);
        bus_write(BASE + 32'h0, 32'h0000_00EE);
        bus_read(BASE + 32'h4, rd, s);
        check_eq("ovf_status", rd, 32'h0000_080D);
        bus_write(BASE + 32'h4, 32'h0000_0007);
        bus_read(BASE + 32'h4, rd, s);
        check_eq("ovf_keep", rd, 32'h0000_080D);
        bus_write(BASE + 32'h4, 32'h0000_0008);
        bus_read(BASE + 32'h4, rd, s);
        check_eq("ovf_clear", rd, 32'h0000_0805);
        k = 0;
        while (irq_o !== 1'b1 && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("drain_irq", {31'd0, irq_o}, 32'd1);
        bus_read(BASE + 32'h4, rd, s);
        check_eq("drain_status", rd, 32'h0000_0002);

        // 4: P clamps to 1 for DIVISOR 0 and 1; back-to-back frames
        bus_write(BASE + 32'h8, 32'd0);
        bus_write(BASE + 32'h0, 32'h0000_00A3);
        bus_write(BASE + 32'h0, 32'h0000_003C);
        frame_check("fA3", 8'hA3, 1, w);
        check_eq("fA3_wait", w, 32'd0);
        frame_check("f3C", 8'h3C, 1, w);
        check_eq("f3C_gap", w, 32'd1);
        bus_write(BASE + 32'h8, 32'd1);
        bus_write(BASE + 32'h0, 32'h0000_0081);
        frame_check("f81", 8'h81, 1, w);
        check_eq("f81_latency", w, 32'd1);

        // 5: divisor change mid-frame applies only to the next frame
        @(posedge clk); #1;
        bus_write(BASE + 32'h8, 32'd4);
        bus_write(BASE + 32'h0, 32'h0000_000F);
        bus_write(BASE + 32'h0, 32'h0000_00F0);
        fork
            begin
                frame_check("f0F", 8'h0F, 4, w);
                frame_check("fF0", 8'hF0, 8, w2);
            end
            begin
                repeat (10) @(posedge clk);
                bus_write(BASE + 32'h8, 32'd8);
            end
        join
        check_eq("f0F_wait", w, 32'd0);
        check_eq("fF0_gap", w2, 32'd1);

        // 6: reset during data bit 3 with OVF set, then out-of-window access
        repeat (3) @(posedge clk); #1;
        bus_write(BASE + 32'h8, 32'd4);
        for (int i = 0; i < 10; i++) bus_write(BASE + 32'h0, 32'h0000_00A5);
        bus_read(BASE + 32'h4, rd, s);
        check_eq("pre_rst_status", rd, 32'h0000_080D);
        repeat (9) @(posedge clk);
        #1;
        check_eq("pre_rst_bit3", {31'd0, txd_o}, 32'd0);
        clrn = 1'b0;
        @(posedge clk);
        #1 clrn = 1'b1;
        check_eq("abort_txd", {31'd0, txd_o}, 32'd1);
        check_eq("abort_irq", {31'd0, irq_o}, 32'd1);
        bus_read(BASE + 32'h4, rd, s);
        check_eq("abort_status", rd, 32'h0000_0002);
        bus_read(BASE + 32'h8, rd, s);
        check_eq("abort_div", rd, 32'd434);

        @(negedge clk);
        ce_i = 1'b1; we_i = 1'b1; addr_i = BASE + 32'h10; wdata_i = 32'h0000_0055;
        #1;
        check_eq("oow_sel", {31'd0, sel_o}, 32'd0);
        check_eq("oow_rdata", rdata_o, 32'd0);
        @(posedge clk); #1;
        addr_i = BASE + 32'h18; wdata_i = 32'd3;
        @(posedge clk); #1;
        ce_i = 1'b0; we_i = 1'b0;
        bus_read(BASE + 32'h14, rd, s);
        check_eq("oow_rd_sel", {31'd0, s}, 32'd0);
        check_eq("oow_rd_data", rd, 32'd0);
        bus_read(BASE + 32'h4, rd, s);
        check_eq("oow_status", rd, 32'h0000_0002);
        bus_read(BASE + 32'h8, rd, s);
        check_eq("oow_div", rd, 32'd434);
        @(posedge clk); #1;
        check_eq("oow_txd", {31'd0, txd_o}, 32'd1);
        check_eq("oow_irq", {31'd0, irq_o}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
